// File: rtl/zion_riscv_bits_ex_pkg.sv
// zion_riscv_bits_ex_pkg: op codes, FSM states and the shared logic-op helper
package zion_riscv_bits_ex_pkg;
  localparam logic [3:0] OP_AND = 4'd0, OP_OR = 4'd1, OP_XOR = 4'd2, OP_ANDN = 4'd3, OP_ORN = 4'd4,
                         OP_XNOR = 4'd5, OP_CLZ = 4'd6, OP_CTZ = 4'd7, OP_CPOP = 4'd8;
  typedef enum logic [3:0] {
    BOP_AND = OP_AND, BOP_OR = OP_OR, BOP_XOR = OP_XOR, BOP_ANDN = OP_ANDN, BOP_ORN = OP_ORN,
    BOP_XNOR = OP_XNOR, BOP_CLZ = OP_CLZ, BOP_CTZ = OP_CTZ, BOP_CPOP = OP_CPOP
  } bits_op_e;
  typedef enum logic [1:0] {IDLE, CNT, DONE} bits_st_e;
  function automatic logic [63:0] LogicOp(input logic [3:0] op, input logic [63:0] s1, input logic [63:0] s2);
    return op == OP_AND ? s1 & s2 : op == OP_OR ? s1 | s2 : op == OP_XOR ? s1 ^ s2 :
           op == OP_ANDN ? s1 & ~s2 : op == OP_ORN ? s1 | ~s2 : ~(s1 ^ s2);
  endfunction
endpackage

// File: rtl/zion_riscv_bits_chunk_cnt.sv
// zion_riscv_bits_chunk_cnt: popcount, leading/trailing zeros and any-one flag of one chunk
module zion_riscv_bits_chunk_cnt #(
  parameter int W = 8,
  parameter int CW = $clog2(W) + 1
) (
  input  logic [W-1:0]  d,
  output logic [CW-1:0] pop,
  output logic [CW-1:0] lz,
  output logic [CW-1:0] tz,
  output logic          any
);
  always_comb begin
    pop = '0;
    lz = CW'(W);
    tz = CW'(W);
    for (int i = 0; i < W; i++) begin
      pop = pop + CW'(d[i]);
      if (d[i]) lz = CW'(W - 1 - i);
    end
    for (int i = W - 1; i >= 0; i--) if (d[i]) tz = CW'(i);
  end
  assign any = |d;
endmodule

// File: rtl/zion_riscv_bits_ex_unit.sv
// zion_riscv_bits_ex_unit: single-cycle logic ops and chunk-iterated CLZ/CTZ/CPOP execute unit
module zion_riscv_bits_ex_unit
  import zion_riscv_bits_ex_pkg::*;
#(
  parameter bit RV64 = 0,
  parameter int CHUNK = 8,
  localparam int XLEN = RV64 ? 64 : 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_flush,
  input  logic            i_vld,
  output logic            i_rdy,
  input  logic [3:0]      i_op,
  input  logic            i_w,
  input  logic [XLEN-1:0] i_s1,
  input  logic [XLEN-1:0] i_s2,
  output logic            o_vld,
  input  logic            o_rdy,
  output logic [XLEN-1:0] o_rslt,
  output logic            o_err
);
  localparam int AW = $clog2(XLEN) + 1;
  localparam int CW = $clog2(CHUNK) + 1;
  localparam int NW = XLEN / CHUNK - 1;
  localparam int NH = (32 / CHUNK > 0 ? 32 / CHUNK : 1) - 1;
  bits_st_e state, nxt;
  logic [XLEN-1:0] sh, lres;
  logic [AW-1:0] acc, cnt, last_idx, add, sum;
  logic [3:0] op;
  logic [CHUNK-1:0] chunk;
  logic [CW-1:0] pop, lz, tz;
  logic any, is_clz, fin, acc_in, is_cnt, w_eff;
  zion_riscv_bits_chunk_cnt #(.W(CHUNK)) u_chunk (.d(chunk), .pop(pop), .lz(lz), .tz(tz), .any(any));
  assign i_rdy = state == IDLE && (!o_vld || o_rdy);
  always_comb begin
    is_clz = op == OP_CLZ;
    chunk = is_clz ? sh[XLEN-1 -: CHUNK] : sh[CHUNK-1:0];
    add = is_clz ? AW'(lz) : op == OP_CTZ ? AW'(tz) : AW'(pop);
    sum = acc + add;
    fin = (op != OP_CPOP && any) || cnt == last_idx;
    acc_in = i_vld && i_rdy;
    is_cnt = i_op == OP_CLZ || i_op == OP_CTZ || i_op == OP_CPOP;
    w_eff = RV64 && i_w;
    lres = XLEN'(LogicOp(i_op, 64'(i_s1), 64'(i_s2)));
    nxt = i_flush ? IDLE :
          state == IDLE ? (acc_in && is_cnt ? CNT : IDLE) :
          state == CNT ? (fin ? DONE : CNT) : (o_rdy ? IDLE : DONE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      o_vld <= 1'b0;
      o_rslt <= '0;
      o_err <= 1'b0;
      sh <= '0;
      acc <= '0;
      cnt <= '0;
      last_idx <= '0;
      op <= OP_AND;
    end else begin
      state <= nxt;
      if (i_flush) begin
        o_vld <= 1'b0;
        o_err <= 1'b0;
      end else if (state == IDLE) begin
        if (o_rdy) begin
          o_vld <= 1'b0;
          o_err <= 1'b0;
        end
        if (acc_in && is_cnt) begin
          op <= i_op;
          acc <= '0;
          cnt <= '0;
          last_idx <= w_eff ? AW'(NH) : AW'(NW);
          sh <= i_op == OP_CLZ ? (w_eff ? i_s1 << (XLEN - 32) : i_s1)
                               : (w_eff ? i_s1 & XLEN'(32'hFFFF_FFFF) : i_s1);
        end else if (acc_in) begin
          o_vld <= 1'b1;
          o_err <= i_op > OP_CPOP;
          o_rslt <= i_op > OP_CPOP ? '0 : lres;
        end
      end else if (state == CNT) begin
        acc <= sum;
        cnt <= cnt + AW'(1);
        sh <= is_clz ? sh << CHUNK : sh >> CHUNK;
        if (fin) begin
          o_vld <= 1'b1;
          o_err <= 1'b0;
          o_rslt <= XLEN'(sum);
        end
      end else if (o_rdy) begin
        o_vld <= 1'b0;
      end
    end
  end
  if (CHUNK < 1 || CHUNK > XLEN || (CHUNK & (CHUNK - 1)) != 0) begin : g_bad_chunk
    $error("CHUNK must be a power of 2 in 1..XLEN");
  end
  a_stable_in: assert property (@(posedge clk) disable iff (!rst_n)
    (i_vld && !i_rdy && !i_flush) |=> (!i_vld || $stable({i_op, i_s1, i_s2})));
endmodule

// File: tb/tb_zion_riscv_bits_ex_unit.sv
// tb_zion_riscv_bits_ex_unit: directed checks of logic, count, back-pressure, flush and reset behaviour
module tb_zion_riscv_bits_ex_unit;
  import zion_riscv_bits_ex_pkg::*;
  logic clk = 1'b0, rst_n, i_flush, i_vld, i_rdy, i_w, o_vld, o_rdy, o_err;
  logic [3:0] i_op;
  logic [63:0] i_s1, i_s2, o_rslt;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  zion_riscv_bits_ex_unit #(.RV64(1), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .i_flush(i_flush), .i_vld(i_vld), .i_rdy(i_rdy), .i_op(i_op), .i_w(i_w),
    .i_s1(i_s1), .i_s2(i_s2), .o_vld(o_vld), .o_rdy(o_rdy), .o_rslt(o_rslt), .o_err(o_err)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [3:0] op, input logic w, input logic [63:0] s1, input logic [63:0] s2);
    i_op = op;
    i_w = w;
    i_s1 = s1;
    i_s2 = s2;
    i_vld = 1'b1;
    for (int k = 0; k < 20 && !i_rdy; k++) @(negedge clk);
    if (!i_rdy) check("issue_rdy", {63'd0, i_rdy}, 64'd1);
    @(negedge clk);
    i_vld = 1'b0;
  endtask
  task automatic run_count(input string tag, input logic [3:0] op, input logic w, input logic [63:0] s1,
                           input logic [63:0] exp, input int lat);
    int cycles;
    issue(op, w, s1, 64'd0);
    cycles = 1;
    while (!o_vld && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    check({tag, "_rslt"}, o_rslt, exp);
    check({tag, "_lat"}, 64'(cycles), 64'(lat));
    check({tag, "_err"}, {63'd0, o_err}, 64'd0);
    @(negedge clk);
  endtask
  localparam logic [63:0] A = 64'hF0F0_0000_FFFF_0000, B = 64'hFF00_FF00_FF00_FF00;
  logic [3:0] ops[5] = '{OP_OR, OP_XOR, OP_ANDN, OP_ORN, OP_XNOR};
  logic [63:0] exps[5] = '{64'hFFF0_FF00_FFFF_FF00, 64'h0FF0_FF00_00FF_FF00, 64'h00F0_0000_00FF_0000,
                           64'hF0FF_00FF_FFFF_00FF, 64'hF00F_00FF_FF00_00FF};
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    logic seen;
    rst_n = 1'b0;
    i_flush = 1'b0;
    i_vld = 1'b0;
    i_op = 4'd0;
    i_w = 1'b0;
    i_s1 = '0;
    i_s2 = '0;
    o_rdy = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_o_vld", {63'd0, o_vld}, 64'd0);
    check("rst_o_rslt", o_rslt, 64'd0);
    check("rst_o_err", {63'd0, o_err}, 64'd0);
    check("rst_i_rdy", {63'd0, i_rdy}, 64'd1);
    rst_n = 1'b1;
    @(negedge clk);
    issue(OP_AND, 1'b1, A, B);
    check("and_vld", {63'd0, o_vld}, 64'd1);
    check("and_rslt", o_rslt, 64'hF000_0000_FF00_0000);
    i_s1 = A;
    i_s2 = B;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("b2b_rdy_%0d", k), {63'd0, i_rdy}, 64'd1);
      i_op = ops[k];
      i_vld = 1'b1;
      @(negedge clk);
      check($sformatf("b2b_rslt_%0d", k), o_rslt, exps[k]);
    end
    i_vld = 1'b0;
    @(negedge clk);
    check("drain_vld", {63'd0, o_vld}, 64'd0);
    o_rdy = 1'b0;
    issue(OP_AND, 1'b0, A, B);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp_rslt_%0d", k), o_rslt, 64'hF000_0000_FF00_0000);
      check($sformatf("bp_vld_%0d", k), {63'd0, o_vld}, 64'd1);
      check($sformatf("bp_irdy_%0d", k), {63'd0, i_rdy}, 64'd0);
      @(negedge clk);
    end
    o_rdy = 1'b1;
    @(negedge clk);
    check("bp_release_vld", {63'd0, o_vld}, 64'd0);
    run_count("clz_bit16", OP_CLZ, 1'b0, 64'h0000_0000_0001_0000, 64'd47, 7);
    run_count("clz_zero", OP_CLZ, 1'b0, 64'd0, 64'd64, 9);
    run_count("cpop_w", OP_CPOP, 1'b1, 64'hFFFF_FFFF_0000_000F, 64'd4, 5);
    run_count("ctz_w", OP_CTZ, 1'b1, 64'hFFFF_FFFF_0000_0000, 64'd32, 5);
    run_count("ctz_msb", OP_CTZ, 1'b0, 64'h8000_0000_0000_0000, 64'd63, 9);
    run_count("clz_w", OP_CLZ, 1'b1, 64'h0000_0000_0080_0000, 64'd8, 3);
    run_count("cpop_ones", OP_CPOP, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd64, 9);
    run_count("ctz_4", OP_CTZ, 1'b0, 64'h10, 64'd4, 2);
    issue(4'd12, 1'b0, A, B);
    check("ill_vld", {63'd0, o_vld}, 64'd1);
    check("ill_err", {63'd0, o_err}, 64'd1);
    check("ill_rslt", o_rslt, 64'd0);
    @(negedge clk);
    check("ill_err_clr", {63'd0, o_err}, 64'd0);
    issue(OP_CLZ, 1'b0, 64'd0, 64'd0);
    repeat (2) @(negedge clk);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    check("flush_i_rdy", {63'd0, i_rdy}, 64'd1);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      seen = seen | o_vld;
      @(negedge clk);
    end
    check("flush_no_vld", {63'd0, seen}, 64'd0);
    i_op = OP_AND;
    i_s1 = '1;
    i_s2 = '1;
    i_vld = 1'b1;
    i_flush = 1'b1;
    @(negedge clk);
    i_vld = 1'b0;
    i_flush = 1'b0;
    check("flush_drop_vld", {63'd0, o_vld}, 64'd0);
    issue(OP_CPOP, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
    @(negedge clk);
    check("cnt_busy_rdy", {63'd0, i_rdy}, 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_vld", {63'd0, o_vld}, 64'd0);
    check("arst_i_rdy", {63'd0, i_rdy}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_count("post_rst", OP_CPOP, 1'b0, 64'h0F0F, 64'd8, 9);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
